// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one bit per clock, LSB first.
// {cout,sum} = a + b + cin after WIDTH clocks in RUN; done pulses for one cycle.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered signed
// overflow output ovf and the operand sign capture that feeds it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last answer
// RUN   | one full-adder step per clock, operands shift right
// DONE  | one-cycle done pulse; sum/cout/ovf valid, start ignored
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_s;
    logic             bit_c;
`ifdef SERIAL_ADDER_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep a copy at accept.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // One full-adder slice operating on the current LSBs and the carry register.
    always_comb begin
        bit_s = a_q[0] ^ b_q[0] ^ carry_q;
        bit_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    end

    // Next-state and datapath update: capture in IDLE, shift/add in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                carry_d = bit_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // bit_s is the sum MSB being shifted in on this edge.
                    ovf_d   = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Status decodes straight from the state register; results from flops.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and random
// operations and a 4-bit instance for the exhaustive sweep. Expected results
// are computed with plain integer arithmetic when an operation is accepted.
// Honours SERIAL_ADDER_OVF_EN the same way the design does.
module tb_serial_adder;

    typedef struct {
        logic [32:0] res;
        logic        ovf;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8, sum8;
    logic [3:0] a4, b4, sum4;
    logic       cin8, cin4, busy8, busy4, done8, done4, cout8, cout4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf4;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    exp_t        q [2][$];
    int          bcnt [2] = '{0, 0};
    logic        hold_ok [2] = '{1'b0, 1'b0};
    logic [32:0] hold_val [2];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Reference: unsigned sum modulo 2^(w+1), signed overflow by range test.
    function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic cv, input int acc);
        exp_t   e;
        longint m, ua, ub, sa, sb, ss;
        m  = longint'(1) << w;
        ua = longint'(av) % m;
        ub = longint'(bv) % m;
        e.res = 33'(ua + ub + longint'(cv));
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ss = sa + sb + longint'(cv);
        e.ovf = (ss >= m / 2) || (ss < -(m / 2));
        e.acc = acc;
        return e;
    endfunction

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    task automatic push(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input int acc);
        q[k].push_back(model(width_of(k), av, bv, cv, acc));
    endtask

    // Monitor body: compare on done, check holding value while idle.
    task automatic mon(input int k, input logic busy, input logic done,
                       input logic [32:0] res, input logic ovf);
        exp_t e;
        if (done === 1'b1) begin
            chk("busy_in_done", k, 64'(busy), 64'd0);
            if (q[k].size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done dut%0d t=%0t: got done=1 expected no pulse", k, $time);
            end else begin
                e = q[k].pop_front();
                chk("result", k, 64'(res), 64'(e.res));
                chk("latency", k, 64'(cyc - e.acc), 64'(width_of(k)));
                chk("busy_cycles", k, 64'(bcnt[k]), 64'(width_of(k)));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", k, 64'(ovf), 64'(e.ovf));
`endif
                hold_val[k] = e.res;
                hold_ok[k]  = 1'b1;
            end
        end else if (busy === 1'b0 && hold_ok[k]) begin
            chk("hold", k, 64'(res), 64'(hold_val[k]));
        end
        if (busy === 1'b1) begin
            bcnt[k]++;
            hold_ok[k] = 1'b0;
        end else if (done !== 1'b1) begin
            bcnt[k] = 0;
        end
    endtask

    always @(negedge clk) begin
`ifdef SERIAL_ADDER_OVF_EN
        mon(0, busy8, done8, 33'({cout8, sum8}), ovf8);
        mon(1, busy4, done4, 33'({cout4, sum4}), ovf4);
`else
        mon(0, busy8, done8, 33'({cout8, sum8}), 1'b0);
        mon(1, busy4, done4, 33'({cout4, sum4}), 1'b0);
`endif
    end

    task automatic wait_idle(input int k);
        int n = 0;
        while ((k == 0) ? (busy8 || done8) : (busy4 || done4)) begin
            if (n == 200) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, expected idle", k, n);
                return;
            end
            @(posedge clk); #2;
            n++;
        end
    endtask

    // Issue one operation; called and returns at 2ns after a rising edge.
    task automatic op(input int k, input logic [31:0] av, input logic [31:0] bv, input logic cv);
        wait_idle(k);
        if (k == 0) begin
            a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv; start8 = 1'b1;
        end else begin
            a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv; start4 = 1'b1;
        end
        @(posedge clk); #2;
        push(k, av, bv, cv, cyc);
        if (k == 0) begin
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end else begin
            start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 0, 64'(busy8), 64'd0);
        chk({nm, "_done"}, 0, 64'(done8), 64'd0);
        chk({nm, "_sum"},  0, 64'(sum8),  64'd0);
        chk({nm, "_cout"}, 0, 64'(cout8), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk({nm, "_ovf"},  0, 64'(ovf8),  64'd0);
`endif
        hold_val[0] = '0; hold_ok[0] = 1'b1;
        hold_val[1] = '0; hold_ok[1] = 1'b1;
    endtask

    initial begin
        int n;
        int c;
        rst = 1'b1;
        start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        // start held through reset is discarded; accept happens on the first free edge
        check_zero("reset");
        rst = 1'b0;
        push(0, 32'h0F, 32'h01, 1'b0, cyc + 1);
        @(posedge clk); #2;
        start8 = 1'b0;

        op(0, 32'hFF, 32'h01, 1'b0);
        op(0, 32'hFF, 32'hFF, 1'b1);
        op(0, 32'h7F, 32'h01, 1'b0);
        op(0, 32'h80, 32'hFF, 1'b0);
        op(0, 32'h05, 32'h03, 1'b0);

        // start pulses in RUN and in DONE with other operands must be ignored
        op(0, 32'h3C, 32'h5A, 1'b1);
        repeat (2) begin @(posedge clk); #2; end
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 50) begin @(posedge clk); #2; n++; end
        chk("done_seen", 0, 64'(done8), 64'd1);
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        chk("start_in_done_ignored", 0, 64'(busy8), 64'd0);

        // reset in the middle of RUN aborts without a done pulse
        op(0, 32'h12, 32'h34, 1'b0);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        void'(q[0].pop_back());
        check_zero("abort");
        op(0, 32'h12, 32'h34, 1'b0);

        // start held high: back-to-back operations one IDLE cycle apart
        wait_idle(0);
        a8 = 8'h21; b8 = 8'h42; cin8 = 1'b1; start8 = 1'b1;
        c = cyc;
        push(0, 32'h21, 32'h42, 1'b1, c + 1);
        push(0, 32'h21, 32'h42, 1'b1, c + 11);
        repeat (11) @(posedge clk);
        #2;
        start8 = 1'b0;

        for (int i = 0; i < 40; i++)
            op(0, $urandom, $urandom, 1'($urandom));

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op(1, 32'(ia), 32'(ib), 1'(ic));

        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
            @(posedge clk); #2; n++;
        end
        chk("drain_q8", 0, 64'(q[0].size()), 64'd0);
        chk("drain_q4", 1, 64'(q[1].size()), 64'd0);
        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
